phy_frame_reader: RTL

- Read-side companion of the per-channel ping-pong capture buffer.
- Waits for a completed frame, walks virtual channels 0..3, and reads each channel's captured words through the buffer read port.
- Emits one header word per channel, followed by that channel's data words, as a valid/ready word stream toward the host link packer.
- Frame length in words equals the capture block's out_size: 4 headers plus the sum of the four channel counts.

---
 rtl/phy_pkg.sv | 38 +++
 rtl/phy_frame_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/phy_pkg.sv
// ============================================================================
// phy_pkg : shared constants, header layout and state encoding for the frame reader
// Rev 1.0
// ============================================================================
`default_nettype none

package phy_pkg;

   localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;
   localparam int         NUM_VCHN        = 4;
   localparam logic [1:0] LAST_VCHN       = 2'(NUM_VCHN - 1);

   localparam int HDR_TAG_LSB  = 24;
   localparam int HDR_VCHN_LSB = 16;
   localparam int HDR_CNT_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_RADDR = 3'd2,
      ST_RWAIT = 3'd3,
      ST_DATA  = 3'd4
   } state_t;

   function automatic logic [31:0] make_hdr(input logic [7:0] tag,
                                            input logic [1:0] vchn,
                                            input logic [7:0] cnt);
      logic [31:0] w;
      w = '0;
      w[HDR_TAG_LSB  +: 8] = tag;
      w[HDR_VCHN_LSB +: 2] = vchn;
      w[HDR_CNT_LSB  +: 8] = cnt;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/phy_frame_reader.sv
// ============================================================================
// phy_frame_reader : walks the four captured channels of a completed frame and
// streams header + data words to the link packer. Rev 1.0
// ============================================================================
`default_nettype none

module phy_frame_reader
   import phy_pkg::*;
#(
   parameter int         RD_LAT  = 1,
   parameter logic [7:0] HDR_TAG = HDR_TAG_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_frame_ready,
   input  logic [15:0] i_out_size,
   input  logic [7:0]  i_data_count,
   output logic [1:0]  o_rd_vchn,
   output logic [7:0]  o_rd_addr,
   input  logic [31:0] i_rd_data,
   output logic [31:0] o_out_data,
   output logic        o_out_vld,
   input  logic        i_out_rdy,
   output logic        o_out_sof,
   output logic        o_out_eof,
   output logic [15:0] o_frame_len,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_overrun,
   input  logic        i_clr_ovr
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t      state_q, state_d;
   logic [1:0]  vchn_q, vchn_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic [1:0]  lat_q, lat_d;
   logic [31:0] data_q, data_d;
   logic [15:0] frame_len_q, frame_len_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic        fr_q;

   logic        w_rise;
   logic        w_more_words;
   logic        w_last_vchn;

   assign w_rise       = i_frame_ready & ~fr_q;
   assign w_last_vchn  = (vchn_q == LAST_VCHN);
   // 9-bit compare so a 255-word channel ends cleanly instead of wrapping
   assign w_more_words = ({1'b0, addr_q} + 9'd1) < {1'b0, cnt_q};

   always_comb begin
      state_d     = state_q;
      vchn_d      = vchn_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      lat_d       = lat_q;
      data_d      = data_q;
      frame_len_d = frame_len_q;
      done_d      = 1'b0;
      ovr_d       = ovr_q;
      o_out_vld   = 1'b0;
      o_out_data  = '0;
      o_out_sof   = 1'b0;
      o_out_eof   = 1'b0;

      if (w_rise && (state_q != ST_IDLE)) begin
         ovr_d = 1'b1;
      end else if (i_clr_ovr) begin
         ovr_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (w_rise) begin
               frame_len_d = i_out_size;
               vchn_d      = 2'd0;
               state_d     = ST_HDR;
            end
         end
         ST_HDR: begin
            // count is sampled every HDR cycle; the buffer half is stable so it cannot change
            cnt_d      = i_data_count;
            o_out_vld  = 1'b1;
            o_out_data = make_hdr(HDR_TAG, vchn_q, i_data_count);
            o_out_sof  = (vchn_q == 2'd0);
            o_out_eof  = w_last_vchn && (i_data_count == 8'd0);
            if (i_out_rdy) begin
               if (i_data_count != 8'd0) begin
                  addr_d  = 8'd0;
                  state_d = ST_RADDR;
               end else if (w_last_vchn) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  vchn_d  = vchn_q + 2'd1;
               end
            end
         end
         ST_RADDR: begin
            lat_d   = 2'd0;
            state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (lat_q == LAT_LAST) begin
               data_d  = i_rd_data;
               state_d = ST_DATA;
            end else begin
               lat_d   = lat_q + 2'd1;
            end
         end
         ST_DATA: begin
            o_out_vld  = 1'b1;
            o_out_data = data_q;
            o_out_eof  = w_last_vchn && !w_more_words;
            if (i_out_rdy) begin
               if (w_more_words) begin
                  addr_d  = addr_q + 8'd1;
                  state_d = ST_RADDR;
               end else if (w_last_vchn) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  vchn_d  = vchn_q + 2'd1;
                  state_d = ST_HDR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         vchn_q      <= 2'd0;
         cnt_q       <= 8'd0;
         addr_q      <= 8'd0;
         lat_q       <= 2'd0;
         data_q      <= 32'd0;
         frame_len_q <= 16'd0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         fr_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         vchn_q      <= vchn_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         lat_q       <= lat_d;
         data_q      <= data_d;
         frame_len_q <= frame_len_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
         fr_q        <= i_frame_ready;
      end
   end

   assign o_rd_vchn   = vchn_q;
   assign o_rd_addr   = addr_q;
   assign o_frame_len = frame_len_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = done_q;
   assign o_overrun   = ovr_q;

endmodule

`default_nettype wire
